// File: rtl/seg7_scan_if.sv
// Purpose: display-side bundle for seg7_scan (scan pace, value/DP inputs, anode/segment drive).
// Latency: none, wires only.
// Backpressure: none, the display consumes continuously.
interface seg7_scan_if;
    logic        CLK1K;
    logic [31:0] DATA;
    logic [7:0]  DP_IN;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        FRAME;

    // Source of the value and the scan pace; it observes the display drive.
    modport master (output CLK1K, DATA, DP_IN, input AN, SEG, DP, FRAME);
    // The scan driver itself.
    modport slave  (input CLK1K, DATA, DP_IN, output AN, SEG, DP, FRAME);
endinterface

// File: rtl/seg7_scan.sv
// Purpose: multiplexed NDIG-digit common-anode hex display driver, paced by CLK1K rising edges.
// Latency: CLK1K rise -> all anodes off after 3 cycles, new digit lit GUARD+1 cycles later.
// Backpressure: none; optional SEG7_LZ_BLANK_EN macro enables leading-zero blanking.
module seg7_scan #(
    parameter int NDIG  = 8,
    parameter int GUARD = 16
) (
    input  logic       CLK50M,
    input  logic       RSTN,
    seg7_scan_if.slave bus
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic {OFF = 1'b0, ON = 1'b1} phase_t;

    logic          s1_q, s2_q, s3_q;
    logic          tick;
    logic          run_q, run_d;
    logic [2:0]    idx_q, idx_d, idx_nxt;
    logic [GW-1:0] gcnt_q, gcnt_d;
    phase_t        phase_q, phase_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    dpsh_q, dpsh_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;
    logic [3:0]    nib;
    logic [6:0]    hex;
    logic          blank;

    // Synchronise the asynchronous pace signal and keep the previous level for edge detect.
    always_ff @(posedge CLK50M) begin
        if (!RSTN) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.CLK1K;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick    = s2_q & ~s3_q;
    assign idx_nxt = (idx_q == 3'(NDIG - 1)) ? 3'd0 : idx_q + 3'd1;

    // Decode the current digit of the frame snapshot, with optional leading-zero blanking.
    always_comb begin
        nib = shadow_q[{idx_q, 2'b00} +: 4];
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'hA: hex = 7'b0001000;
            4'hB: hex = 7'b0000011;
            4'hC: hex = 7'b1000110;
            4'hD: hex = 7'b0100001;
            4'hE: hex = 7'b0000110;
            4'hF: hex = 7'b0001110;
            default: hex = 7'h7F;
        endcase
`ifdef SEG7_LZ_BLANK_EN
        blank = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
`else
        blank = 1'b0;
`endif
    end

    // Scan FSM: a tick blanks and advances; the guard count runs out before the digit lights.
    always_comb begin
        run_d    = run_q;
        idx_d    = idx_q;
        gcnt_d   = gcnt_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        dpsh_d   = dpsh_q;
        an_d     = 8'hFF;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        frame_d  = 1'b0;
        if (tick) begin
            run_d   = 1'b1;
            idx_d   = idx_nxt;
            gcnt_d  = GW'(GUARD);
            phase_d = OFF;
            if (idx_nxt == 3'd0) begin
                shadow_d = bus.DATA;
                dpsh_d   = bus.DP_IN;
                frame_d  = 1'b1;
            end
        end else if (phase_q == OFF) begin
            if (gcnt_q != '0) begin
                gcnt_d = gcnt_q - GW'(1);
            end else if (run_q) begin
                // Guard expired: light the digit in the same cycle the phase flips.
                phase_d     = ON;
                an_d[idx_q] = 1'b0;
                seg_d       = blank ? 7'h7F : hex;
                dp_d        = ~dpsh_q[idx_q];
            end
        end else begin
            an_d[idx_q] = 1'b0;
            seg_d       = blank ? 7'h7F : hex;
            dp_d        = ~dpsh_q[idx_q];
        end
    end

    // State and registered outputs; run_q keeps the display dark until the first tick.
    always_ff @(posedge CLK50M) begin
        if (!RSTN) begin
            run_q    <= 1'b0;
            idx_q    <= 3'(NDIG - 1);
            gcnt_q   <= '0;
            phase_q  <= OFF;
            shadow_q <= 32'd0;
            dpsh_q   <= 8'd0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            run_q    <= run_d;
            idx_q    <= idx_d;
            gcnt_q   <= gcnt_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            dpsh_q   <= dpsh_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.DP    = dp_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Purpose: randomized bench for seg7_scan against a frame/digit-level reference model.
// Latency: model acts 3 cycles after each CLK1K rise and lights GUARD+1 cycles later.
// Backpressure: none.
module tb_seg7_scan;

    localparam int NDIG  = 8;
    localparam int GUARD = 16;

    logic CLK50M = 1'b0;
    logic RSTN   = 1'b0;

    seg7_scan_if bus ();

    seg7_scan #(.NDIG(NDIG), .GUARD(GUARD)) dut (
        .CLK50M (CLK50M),
        .RSTN   (RSTN),
        .bus    (bus)
    );

    always #10 CLK50M = ~CLK50M;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int          pe = 0;
    logic [31:0] data_pe;
    logic [7:0]  dp_pe;
    logic        rst_pe;
    int          act_q[$];
    int          digit = NDIG - 1;
    bit          lit = 1'b0;
    int          last = 0;
    logic [31:0] sh = 32'd0;
    logic [7:0]  dsh = 8'd0;
    bit          frm = 1'b0;

    logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, pe, got, exp);
        end
    endtask

    // Capture what the DUT sees at each active edge.
    always @(posedge CLK50M) begin
        pe++;
        data_pe = bus.DATA;
        dp_pe   = bus.DP_IN;
        rst_pe  = RSTN;
    end

    // Advance the model for the edge just taken and compare the outputs.
    always @(negedge CLK50M) begin
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         nb;
        bit         blank;
        if (pe > 0) begin
            frm = 1'b0;
            if (!rst_pe) begin
                digit = NDIG - 1;
                lit   = 1'b0;
                sh    = 32'd0;
                dsh   = 8'd0;
                act_q.delete();
            end else begin
                while (act_q.size() > 0 && act_q[0] <= pe) begin
                    void'(act_q.pop_front());
                    digit = (digit == NDIG - 1) ? 0 : digit + 1;
                    lit   = 1'b1;
                    last  = pe;
                    if (digit == 0) begin
                        sh  = data_pe;
                        dsh = dp_pe;
                        frm = 1'b1;
                    end
                end
            end
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if (lit && (pe - last) > GUARD) begin
                nb    = int'((sh >> (4 * digit)) & 32'hF);
`ifdef SEG7_LZ_BLANK_EN
                blank = (digit > 0) && ((sh >> (4 * digit)) == 32'd0);
`else
                blank = 1'b0;
`endif
                e_an  = ~(8'h01 << digit);
                e_seg = blank ? 7'h7F : segtab[nb];
                e_dp  = ~dsh[digit];
            end
            check("AN",    32'(bus.AN),    32'(e_an));
            check("SEG",   32'(bus.SEG),   32'(e_seg));
            check("DP",    32'(bus.DP),    32'(e_dp));
            check("FRAME", 32'(bus.FRAME), 32'(frm));
        end
    end

    function automatic logic [31:0] pick_data();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0: pick_data = v;
            1: pick_data = v >> $urandom_range(0, 31);
            2: pick_data = 32'h0000_0000;
            3: pick_data = 32'hFFFF_FFFF;
            default: pick_data = 32'h1234_ABCD;
        endcase
    endfunction

    task automatic run_cycles(input int n, input bit churn);
        repeat (n) begin
            @(negedge CLK50M);
            if (churn && $urandom_range(0, 15) == 0) begin
                bus.DATA  = pick_data();
                bus.DP_IN = 8'($urandom);
            end
        end
    endtask

    task automatic pulse(input int hi, input int lo, input bit churn);
        @(negedge CLK50M);
        bus.CLK1K = 1'b1;
        act_q.push_back(pe + 3);
        run_cycles(hi, churn);
        bus.CLK1K = 1'b0;
        run_cycles(lo, churn);
    endtask

    task automatic pulse_reset();
        run_cycles(5, 1'b0);
        RSTN = 1'b0;
        @(negedge CLK50M);
        RSTN = 1'b1;
        run_cycles(3, 1'b0);
    endtask

    initial begin
        bus.CLK1K = 1'b0;
        bus.DATA  = 32'h1234_ABCD;
        bus.DP_IN = 8'h05;
        RSTN      = 1'b0;
        repeat (3) @(negedge CLK50M);
        RSTN = 1'b1;
        run_cycles(10, 1'b0);

        // Two full frames with slow pace: every digit gets a lit period.
        repeat (2 * NDIG + 1) pulse(30, 30, 1'b0);

        // Value change from all-zero to all-ones in the middle of a frame.
        bus.DATA  = 32'h0000_0000;
        bus.DP_IN = 8'h00;
        repeat (NDIG + 3) pulse(25, 25, 1'b0);
        bus.DATA = 32'hFFFF_FFFF;
        repeat (NDIG + 2) pulse(25, 25, 1'b0);

        // Leading-zero patterns.
        bus.DATA = 32'h0000_00A0;
        repeat (NDIG + 1) pulse(25, 25, 1'b0);

        // Reset in the middle of a lit digit.
        pulse(20, 20, 1'b0);
        pulse_reset();
        repeat (NDIG + 1) pulse(25, 25, 1'b0);

        // Random pace (including ticks inside the guard window) and churning inputs.
        for (int i = 0; i < 300; i++) begin
            pulse($urandom_range(3, 40), $urandom_range(3, 40), 1'b1);
            if (i % 100 == 50) pulse_reset();
        end
        run_cycles(60, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
